// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types.
//   lc3b_word      : 16-bit data / address word
//   lc3b_mem_wmask : per-byte write mask, bit0 = [7:0], bit1 = [15:8]
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with byte-enabled synchronous write and combinational read.
// No reset: contents survive rst of the enclosing responder.
//   clk   : write clock
//   we    : write strobe, qualified per byte by be
//   be    : byte enables
//   addr  : word index shared by read and write
//   wdata : write data
//   rdata : combinational read of the word at addr
module mem_array
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  lc3b_mem_wmask be,
    input  logic [AW-1:0] addr,
    input  lc3b_word      wdata,
    output lc3b_word      rdata
);

    lc3b_word mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem_q[addr][7:0]  <= wdata[7:0];
            if (be[1]) mem_q[addr][15:8] <= wdata[15:8];
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for a held read/write request handshake.
//   clk, rst        : clock, synchronous active-high reset
//   mem_read/write  : request strobes, held by the initiator until mem_resp
//   mem_address     : byte address; word index is address[log2(DEPTH_WORDS):1]
//   mem_wdata       : write data
//   mem_byte_enable : write byte mask
//   mem_resp        : single-cycle completion pulse, LATENCY cycles after acceptance
//   mem_rdata       : registered read data, held until the next completed read
//   proto_err       : sticky flag for aborted requests or read+write collisions
module mem_responder
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          proto_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    lc3b_word      wdata_q, wdata_d;
    lc3b_mem_wmask be_q, be_d;
    logic          is_write_q, is_write_d;
    logic          mem_resp_q, mem_resp_d;
    lc3b_word      rdata_q, rdata_d;
    logic          proto_err_q, proto_err_d;

    logic          enter_resp;
    logic          req;
    logic [AW-1:0] cur_idx;
    lc3b_word      cur_wdata;
    lc3b_mem_wmask cur_be;
    logic          cur_write;
    logic          mem_we;
    lc3b_word      mem_rd_data;

    // Bit 0 and bits above the word index are deliberately ignored (address aliasing).
    logic unused_addr;
    assign unused_addr = ^mem_address;

    assign req = mem_read | mem_write;

    // With LATENCY=1 the response edge is the acceptance edge, so the live
    // inputs must feed the array; otherwise the latched copies are used.
    always_comb begin
        if (state_q == StIdle) begin
            cur_idx   = mem_address[AW:1];
            cur_wdata = mem_wdata;
            cur_be    = mem_byte_enable;
            cur_write = mem_write;
        end else begin
            cur_idx   = idx_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
            cur_write = is_write_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        is_write_d  = is_write_q;
        mem_resp_d  = 1'b0;
        rdata_d     = rdata_q;
        proto_err_d = proto_err_q;
        enter_resp  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d      = mem_address[AW:1];
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_enable;
                    // A read+write collision is handled as a write.
                    is_write_d = mem_write;
                    if (mem_read && mem_write) proto_err_d = 1'b1;
                    cnt_d = 4'(LATENCY - 1);
                    if (LATENCY == 1) enter_resp = 1'b1;
                    else              state_d    = StBusy;
                end
            end
            StBusy: begin
                if (!req) begin
                    state_d     = StIdle;
                    cnt_d       = 4'd0;
                    proto_err_d = 1'b1;
                end else if (cnt_q <= 4'd1) begin
                    // Counter reaches zero on this edge: response in the next cycle.
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // Requests still held here are the one just answered; never accept.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (enter_resp) begin
            state_d    = StResp;
            cnt_d      = 4'd0;
            mem_resp_d = 1'b1;
            if (!cur_write) rdata_d = mem_rd_data;
        end
    end

    assign mem_we = enter_resp && cur_write && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            is_write_q  <= 1'b0;
            mem_resp_q  <= 1'b0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            is_write_q  <= is_write_d;
            mem_resp_q  <= mem_resp_d;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem_array (
        .clk  (clk),
        .we   (mem_we),
        .be   (cur_be),
        .addr (cur_idx),
        .wdata(cur_wdata),
        .rdata(mem_rd_data)
    );

    assign mem_resp  = mem_resp_q;
    assign mem_rdata = rdata_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: each request pushes its expected read data
// and response cycle; a negedge monitor pops and compares on every mem_resp.
module tb_mem_responder;

    localparam int unsigned LAT = 3;

    typedef struct {
        logic [15:0] rdata;
        int          resp_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [15:0] mem_address = '0, mem_wdata = '0;
    logic [1:0]  mem_byte_enable = '0;
    logic        mem_resp, proto_err;
    logic [15:0] mem_rdata;

    logic        rst2 = 1'b0;
    logic        rd2 = 1'b0;
    logic        resp2, perr2;
    logic [15:0] rdata2;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb_q[$];
    logic [15:0] model_mem [256];
    logic [15:0] model_rdata = '0;

    logic        win2 = 1'b0;
    logic        prev2 = 1'b0;
    int          last2 = 0;
    int          cnt2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.LATENCY(LAT), .DEPTH_WORDS(256)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .proto_err      (proto_err)
    );

    mem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) u_dut_l2 (
        .clk            (clk),
        .rst            (rst2),
        .mem_read       (rd2),
        .mem_write      (1'b0),
        .mem_address    (16'h0000),
        .mem_wdata      (16'h0000),
        .mem_byte_enable(2'b00),
        .mem_resp       (resp2),
        .mem_rdata      (rdata2),
        .proto_err      (perr2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Main-DUT response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (mem_resp) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_resp", 32'(mem_resp), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("resp_rdata", 32'(mem_rdata), 32'(e.rdata));
                check_eq("resp_cycle", 32'(cyc), 32'(e.resp_cyc));
            end
        end
    end

    // LATENCY=2 instance: held read must pulse every 3 cycles, never back to back.
    always @(negedge clk) begin
        if (win2 && resp2) begin
            check_eq("l2_back_to_back", 32'(prev2), 32'd0);
            if (cnt2 > 0) check_eq("l2_period", 32'(cyc - last2), 32'd3);
            last2 = cyc;
            cnt2++;
        end
        prev2 = resp2;
    end

    // Drive one request now (caller sits just after a rising edge) and hold it
    // until mem_resp; returns just after the following rising edge.
    task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] data, input logic [1:0] be);
        exp_t e;
        logic seen;
        logic [7:0] idx;
        idx = addr[8:1];
        if (wr) begin
            if (be[0]) model_mem[idx][7:0]  = data[7:0];
            if (be[1]) model_mem[idx][15:8] = data[15:8];
        end else begin
            model_rdata = model_mem[idx];
        end
        e.rdata    = model_rdata;
        e.resp_cyc = cyc + LAT;
        sb_q.push_back(e);
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_wdata = data; mem_byte_enable = be;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_eq("resp_seen", 32'(seen), 32'd1);
            void'(sb_q.pop_front());
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rdata = '0;
        check_eq("rst_resp", 32'(mem_resp), 32'd0);
        check_eq("rst_rdata", 32'(mem_rdata), 32'd0);
        check_eq("rst_proto_err", 32'(proto_err), 32'd0);
    endtask

    initial begin
        rst2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        do_reset();

        // Basic write then read, latency checked by the monitor.
        txn(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b11);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);

        // Byte enables, including an all-disabled write that must still respond.
        txn(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b11);
        txn(1'b0, 1'b1, 16'h0020, 16'h00AA, 2'b01);
        txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11);
        txn(1'b0, 1'b1, 16'h0020, 16'h0000, 2'b00);
        txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);

        // Aliasing: 0201h maps to word 0.
        txn(1'b0, 1'b1, 16'h0201, 16'hBEEF, 2'b11);
        txn(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b11);

        // Abort: read dropped in the second BUSY cycle.
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11);
        mem_read = 1'b1; mem_address = 16'h0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_proto_err", 32'(proto_err), 32'd1);
        check_eq("abort_rdata_held", 32'(mem_rdata), 32'h1234);
        // FSM must already be idle: a new request here has exact latency.
        txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11);
        do_reset();

        // Read+write collision: treated as write, rdata untouched, error flagged.
        txn(1'b1, 1'b1, 16'h0040, 16'hABCD, 2'b11);
        check_eq("both_proto_err", 32'(proto_err), 32'd1);
        check_eq("both_rdata_held", 32'(mem_rdata), 32'h0000);
        txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11);
        do_reset();

        // Reset during BUSY of a write: no response, no storage update.
        txn(1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11);
        mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'h5555;
        mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b11);

        // Held read on the LATENCY=2 instance for 20 cycles.
        rd2 = 1'b1;
        win2 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        win2 = 1'b0;
        rd2 = 1'b0;
        check_eq("l2_pulse_count", 32'(cnt2), 32'd6);

        repeat (6) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
